// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant so fetch cannot starve.
module imem_dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [1:0]  proc2mem_cmd,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req (and its address/data) high until its done
  // pulse; the memory takes a command on any cycle with mem_ready high while the
  // command is non-NONE, and returns exactly one mem_rvalid per accepted command.

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_t;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t     state;
  owner_t     owner;
  logic [3:0] streak;
  logic       squash;

  logic fetch_ok;
  logic at_limit;
  logic grant_if;
  logic grant_d;
  logic flush_hit;

  always_comb begin
    fetch_ok  = if_req & ~if_flush;
    at_limit  = (streak == LIMIT);
    grant_if  = fetch_ok & (~d_req | at_limit);
    grant_d   = d_req & ~grant_if;
    flush_hit = if_flush & (owner == OWN_IF);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      streak        <= 4'd0;
      squash        <= 1'b0;
      if_done       <= 1'b0;
      if_rdata      <= 32'd0;
      d_done        <= 1'b0;
      d_rdata       <= 32'd0;
      proc2mem_cmd  <= CMD_NONE;
      proc2mem_addr <= 32'd0;
      proc2mem_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner         <= OWN_D;
            proc2mem_cmd  <= d_we ? CMD_STORE : CMD_LOAD;
            proc2mem_addr <= d_addr & ~32'h3;
            proc2mem_data <= d_wdata;
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (if_req) streak <= at_limit ? streak : streak + 4'd1;
            else        streak <= 4'd0;
            state         <= ISSUE;
          end else if (grant_if) begin
            owner         <= OWN_IF;
            proc2mem_cmd  <= CMD_LOAD;
            proc2mem_addr <= if_addr & ~32'h3;
            proc2mem_data <= 32'd0;
            streak        <= 4'd0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_hit && !mem_ready) begin
            // Memory never saw this fetch, so it can be dropped outright.
            proc2mem_cmd  <= CMD_NONE;
            proc2mem_addr <= 32'd0;
            proc2mem_data <= 32'd0;
            owner         <= OWN_NONE;
            state         <= IDLE;
          end else if (mem_ready) begin
            proc2mem_cmd  <= CMD_NONE;
            proc2mem_addr <= 32'd0;
            proc2mem_data <= 32'd0;
            if (flush_hit) squash <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner == OWN_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= ~(squash | if_flush);
            end
            state <= RESP;
          end else if (flush_hit) begin
            squash <= 1'b1;
          end
        end
        RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          squash  <= 1'b0;
          owner   <= OWN_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: load, store with backpressure, starvation
// guard, fetch flushes, and asynchronous reset mid-transaction.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [1:0]  proc2mem_cmd;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;
  int n_if_done;
  int n_d_done;
  int if_base;
  int d_base;

  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  imem_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .proc2mem_cmd(proc2mem_cmd), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done-pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (if_done) n_if_done++;
    if (d_done)  n_d_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({tag, "_cmd"}, 32'(proc2mem_cmd), 32'd0);
    chk({tag, "_addr"}, proc2mem_addr, 32'd0);
    chk({tag, "_data"}, proc2mem_data, 32'd0);
    chk({tag, "_if_done"}, 32'(if_done), 32'd0);
    chk({tag, "_d_done"}, 32'(d_done), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_if_done = 0; n_d_done = 0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Load only
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0104; mem_ready = 1'b1;
    tick();
    chk("ld_state_c1", 32'(dbg_state), 32'(S_ISSUE));
    chk("ld_cmd_c1", 32'(proc2mem_cmd), 32'd1);
    chk("ld_addr_c1", proc2mem_addr, 32'h0000_0104);
    tick();
    chk("ld_state_c2", 32'(dbg_state), 32'(S_WAIT));
    chk("ld_cmd_c2", 32'(proc2mem_cmd), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ld_done_c3", 32'(d_done), 32'd1);
    chk("ld_rdata_c3", d_rdata, 32'hDEAD_BEEF);
    mem_rvalid = 1'b0; d_req = 1'b0;
    tick();
    chk("ld_done_c4", 32'(d_done), 32'd0);
    chk("ld_state_c4", 32'(dbg_state), 32'(S_IDLE));
    chk("ld_rdata_hold", d_rdata, 32'hDEAD_BEEF);
    chk("ld_if_done_cnt", 32'(n_if_done), 32'd0);
    chk("ld_d_done_cnt", 32'(n_d_done), 32'd1);

    // Store with three cycles of backpressure
    d_base = n_d_done;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0203; d_wdata = 32'h1234_5678;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_state", 32'(dbg_state), 32'(S_ISSUE));
      chk("st_cmd", 32'(proc2mem_cmd), 32'd2);
      chk("st_addr", proc2mem_addr, 32'h0000_0200);
      chk("st_data", proc2mem_data, 32'h1234_5678);
    end
    mem_ready = 1'b1;
    tick();
    chk("st_wait", 32'(dbg_state), 32'(S_WAIT));
    chk("st_cmd_none", 32'(proc2mem_cmd), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'd0;
    tick();
    chk("st_done", 32'(d_done), 32'd1);
    mem_rvalid = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) tick();
    chk("st_single_done", 32'(n_d_done - d_base), 32'd1);

    // Starvation guard: both requesters held high for ten grants
    if_base = n_if_done; d_base = n_d_done;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("starve_grant%0d", i), proc2mem_addr,
          (i == 4 || i == 9) ? 32'h0000_1000 : 32'h0000_0300);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      mem_rvalid = 1'b0;
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    chk("starve_if_dones", 32'(n_if_done - if_base), 32'd2);
    chk("starve_d_dones", 32'(n_d_done - d_base), 32'd8);
    chk("starve_if_rdata", if_rdata, 32'hA000_0009);

    // Flush before accept, with a data request waiting behind it
    if_base = n_if_done;
    if_req = 1'b1; if_addr = 32'h0000_2000; mem_ready = 1'b0;
    tick();
    chk("fl1_cmd_c1", 32'(proc2mem_cmd), 32'd1);
    chk("fl1_addr_c1", proc2mem_addr, 32'h0000_2000);
    if_flush = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    tick();
    chk("fl1_cmd_c2", 32'(proc2mem_cmd), 32'd0);
    chk("fl1_state_c2", 32'(dbg_state), 32'(S_IDLE));
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    chk("fl1_d_grant", proc2mem_addr, 32'h0000_0400);
    mem_ready = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    chk("fl1_d_done", 32'(d_done), 32'd1);
    chk("fl1_d_rdata", d_rdata, 32'h0000_0055);
    mem_rvalid = 1'b0; d_req = 1'b0;
    tick();
    chk("fl1_no_if_done", 32'(n_if_done - if_base), 32'd0);

    // Flush while waiting; response arrives two cycles later
    if_req = 1'b1; if_addr = 32'h0000_3000;
    tick();
    tick();
    chk("fl2_wait", 32'(dbg_state), 32'(S_WAIT));
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    chk("fl2_resp", 32'(dbg_state), 32'(S_RESP));
    chk("fl2_if_done", 32'(if_done), 32'd0);
    mem_rvalid = 1'b0;
    tick();
    chk("fl2_no_if_done", 32'(n_if_done - if_base), 32'd0);

    // Next fetch completes normally
    if_req = 1'b1; if_addr = 32'h0000_3004;
    tick();
    chk("nf_addr", proc2mem_addr, 32'h0000_3004);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0088;
    tick();
    chk("nf_if_done", 32'(if_done), 32'd1);
    chk("nf_if_rdata", if_rdata, 32'h0000_0088);
    mem_rvalid = 1'b0; if_req = 1'b0;
    tick();

    // Flush and response in the same WAIT cycle: squash wins
    if_base = n_if_done;
    if_req = 1'b1; if_addr = 32'h0000_3008;
    tick();
    tick();
    if_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    chk("sim_if_done", 32'(if_done), 32'd0);
    if_flush = 1'b0; mem_rvalid = 1'b0; if_req = 1'b0;
    tick();
    chk("sim_no_if_done", 32'(n_if_done - if_base), 32'd0);

    // Asynchronous reset in the middle of WAIT
    if_base = n_if_done; d_base = n_d_done;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    tick();
    tick();
    chk("ar_wait", 32'(dbg_state), 32'(S_WAIT));
    #2;
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0; mem_rvalid = 1'b0;
    chk("ar_no_done", 32'((n_if_done - if_base) + (n_d_done - d_base)), 32'd0);
    tick();
    chk("ar_issue_c1", 32'(dbg_state), 32'(S_ISSUE));
    chk("ar_addr_c1", proc2mem_addr, 32'h0000_0500);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00BB;
    tick();
    chk("ar_done_c3", 32'(d_done), 32'd1);
    chk("ar_rdata_c3", d_rdata, 32'h0000_00BB);
    mem_rvalid = 1'b0; d_req = 1'b0;
    tick();
    chk("ar_idle", 32'(dbg_state), 32'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sequences one transaction at a time through a request/accept/response handshake.
- Data accesses have priority; a starvation guard forces a fetch grant after a bounded run of data grants.
- A fetch in flight is squashed on a taken branch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done or squash
- if_addr  in  32  fetch address; held stable while if_req is high
- if_flush  in  1  taken-branch squash of the outstanding fetch
- if_done  out  1  one-cycle pulse; if_rdata is valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_done  out  1  one-cycle pulse; load data valid, or store complete
- d_rdata  out  32  load data
- proc2mem_cmd  out  2  0 = NONE, 1 = LOAD, 2 = STORE
- proc2mem_addr  out  32  word-aligned address; bits [1:0] forced to 0
- proc2mem_data  out  32  store data
- mem_ready  in  1  memory accepts the command this cycle
- mem_rvalid  in  1  response valid; one per accepted command, loads and stores alike
- mem_rdata  in  32  response data

Behaviour:
- Reset (async): state = IDLE; all outputs 0; proc2mem_cmd = NONE; streak counter = 0; owner = none; squash flag = 0.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, arbitration at the clock edge:
  - d_req only: grant data.
  - if_req only, with if_flush low: grant fetch.
  - Both pending: grant data unless streak == STARVE_LIMIT, then grant fetch.
  - A grant latches owner, address, write data and command, then moves to ISSUE.
  - No request: stay in IDLE.
  - A fetch request with if_flush high in the same cycle is not granted.
- ISSUE:
  - proc2mem_cmd/addr/data driven from the latched values.
  - mem_ready = 1 at the edge: go to WAIT; cmd returns to NONE next cycle.
  - mem_ready = 0: hold the command unchanged.
- WAIT:
  - mem_rvalid = 1: capture mem_rdata and go to RESP.
  - mem_rvalid in any other state is ignored.
- RESP:
  - Owner's done pulses for exactly this cycle; rdata holds the captured value until the next response.
  - Always returns to IDLE; no arbitration happens in RESP, so requesters may drop req while done is high.
- Minimum latency, with mem_ready high in ISSUE and mem_rvalid one cycle after acceptance:
  - req sampled at edge 0; cmd visible in cycle 1; WAIT in cycle 2; rvalid in cycle 2; done in cycle 3.
  - Back-to-back transactions therefore take 4 cycles minimum.
- Streak counter:
  - Data grant while if_req is high: streak increments, saturating at STARVE_LIMIT.
  - Fetch grant, or any data grant with if_req low: streak resets to 0.
- Flush, owner = fetch:
  - In ISSUE with mem_ready low: drop the command (cmd = NONE next cycle) and return to IDLE. The memory never saw the command.
  - In ISSUE with mem_ready high, or in WAIT: set the squash flag. The transaction completes normally but if_done is suppressed in RESP. The flag clears on return to IDLE.
  - if_flush has no effect when the owner is data or the state is IDLE/RESP.
- Simultaneous events:
  - if_flush and mem_rvalid in the same WAIT cycle: squash wins.
  - d_req and if_req both rising in RESP: arbitration happens in the following IDLE cycle.
- rst mid-transaction: aborts immediately with no done pulse. The memory side is responsible for discarding any outstanding response.

Test Plan:
- Load only: d_req = 1, d_we = 0, d_addr = 0x0000_0104; mem_ready = 1; mem_rvalid 1 cycle after accept with mem_rdata = 0xDEAD_BEEF.
  - Required: cmd = LOAD, addr = 0x104 in cycle 1; d_done pulse in cycle 3 with d_rdata = 0xDEAD_BEEF; if_done never asserts.
- Store with backpressure: d_we = 1, d_addr = 0x0000_0203, d_wdata = 0x1234_5678; mem_ready low for 3 cycles.
  - Required: cmd = STORE, addr = 0x200, data = 0x1234_5678 held stable all 4 ISSUE cycles; a single d_done pulse.
- Starvation guard, STARVE_LIMIT = 4: if_req and d_req held high continuously.
  - Required: grant sequence D, D, D, D, I, D, D, D, D, I.
- Flush before accept: fetch owner, mem_ready = 0, if_flush pulses in cycle 1.
  - Required: cmd = NONE in cycle 2; state IDLE; no if_done; a pending d_req is then granted.
- Flush in WAIT: if_flush pulses while waiting; mem_rvalid arrives 2 cycles later.
  - Required: no if_done pulse; if_rdata may update; next request proceeds normally.
- Async reset mid-WAIT: rst asserted between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no done pulse; after release, first d_req completes in 4 cycles.
